// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: sequences M-mode trap entry and MRET over the shared CSR set/clear bus
// Ports:
//   clk_i, rst_i (async, active-low)
//   trap_req_i/trap_cause_i/trap_pc_i   trap request with mcause/mepc values
//   mret_req_i                          MRET request
//   core_req_i/core_addr_i/core_set_i/core_clear_i/core_gnt_o   core CSR access
//   mstatus_i                           current mstatus (bit3 MIE, bit7 MPIE)
//   csr_en_o/csr_addr_o/csr_set_o/csr_clear_o/csr_ack_i         CSR bus
//   busy_o, trap_done_o, mret_done_o, err_o                     status
module csr_trap_sequencer #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter int          ACK_TIMEOUT  = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_req_i,
    input  logic        core_req_i,
    input  logic [11:0] core_addr_i,
    input  logic [31:0] core_set_i,
    input  logic [31:0] core_clear_i,
    output logic        core_gnt_o,
    input  logic [31:0] mstatus_i,
    output logic        csr_en_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_set_o,
    output logic [31:0] csr_clear_o,
    input  logic        csr_ack_i,
    output logic        busy_o,
    output logic        trap_done_o,
    output logic        mret_done_o,
    output logic        err_o
);
    localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, T_MSTATUS, T_MEPC, T_MCAUSE, R_MSTATUS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   cause;
    logic [31:0]   pc;
    logic          idle;
    logic          core_pass;
    logic          expire;
    logic          mie;
    logic          mpie;

    assign idle = state == IDLE;
    assign mie  = mstatus_i[3];
    assign mpie = mstatus_i[7];
    // core traffic only passes while the sequencer has nothing to do; gated by
    // reset so every output is quiet while rst_i is low
    assign core_pass = rst_i && idle && core_req_i && !trap_req_i && !mret_req_i;
    assign expire    = !idle && !csr_ack_i && cnt == LAST;

    always_comb begin
        csr_en_o    = !idle || core_pass;
        csr_addr_o  = (state == T_MSTATUS || state == R_MSTATUS) ? MSTATUS_ADDR :
                      state == T_MEPC   ? MEPC_ADDR :
                      state == T_MCAUSE ? MCAUSE_ADDR :
                      core_pass ? core_addr_i : '0;
        // trap: MPIE<=MIE, MIE<=0; mret: MIE<=MPIE, MPIE<=1; masks kept disjoint
        csr_set_o   = state == T_MSTATUS ? {24'b0, mie, 7'b0} :
                      state == R_MSTATUS ? {24'b0, 1'b1, 3'b0, mpie, 3'b0} :
                      state == T_MEPC   ? pc :
                      state == T_MCAUSE ? cause :
                      core_pass ? core_set_i : '0;
        csr_clear_o = state == T_MSTATUS ? {24'b0, !mie, 3'b0, 1'b1, 3'b0} :
                      state == R_MSTATUS ? {28'b0, !mpie, 3'b0} :
                      state == T_MEPC   ? ~pc :
                      state == T_MCAUSE ? ~cause :
                      core_pass ? core_clear_i : '0;
        core_gnt_o  = core_pass && csr_ack_i;
        busy_o      = !idle;
        trap_done_o = state == T_MCAUSE && csr_ack_i;
        mret_done_o = state == R_MSTATUS && csr_ack_i;
        err_o       = expire;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            cause <= '0;
            pc    <= '0;
        end else if (idle) begin
            cnt <= '0;
            if (trap_req_i) begin
                cause <= trap_cause_i;
                pc    <= trap_pc_i;
                state <= T_MSTATUS;
            end else if (mret_req_i) begin
                state <= R_MSTATUS;
            end
        end else if (csr_ack_i) begin
            cnt   <= '0;
            state <= state == T_MSTATUS ? T_MEPC : state == T_MEPC ? T_MCAUSE : IDLE;
        end else if (expire) begin
            cnt   <= '0;
            state <= IDLE;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: randomized self-checking bench against a CSR register model
module tb_csr_trap_sequencer;
    localparam int TO = 15;

    logic        clk_i = 0;
    logic        rst_i = 1;
    logic        trap_req = 0;
    logic [31:0] trap_cause = 0;
    logic [31:0] trap_pc = 0;
    logic        mret_req = 0;
    logic        core_req = 0;
    logic [11:0] core_addr = 0;
    logic [31:0] core_set = 0;
    logic [31:0] core_clear = 0;
    logic        core_gnt;
    logic [31:0] mst = 0;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_set;
    logic [31:0] csr_clear;
    logic        csr_ack = 0;
    logic        busy;
    logic        trap_done;
    logic        mret_done;
    logic        err;

    logic [31:0] mepc = 0;
    logic [31:0] mcause = 0;
    logic [31:0] lat_pc;
    logic [31:0] lat_cause;
    logic [31:0] ms_set;
    logic [31:0] ms_clr;
    int tests = 0;
    int fails = 0;

    csr_trap_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .trap_req_i(trap_req), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
        .mret_req_i(mret_req),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_set_i(core_set),
        .core_clear_i(core_clear), .core_gnt_o(core_gnt),
        .mstatus_i(mst),
        .csr_en_o(csr_en), .csr_addr_o(csr_addr), .csr_set_o(csr_set),
        .csr_clear_o(csr_clear), .csr_ack_i(csr_ack),
        .busy_o(busy), .trap_done_o(trap_done), .mret_done_o(mret_done), .err_o(err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit mapped(input logic [11:0] a);
        return a == 12'h300 || a == 12'h341 || a == 12'h342;
    endfunction

    // CSR register blocks: apply a set/clear write
    task automatic apply(input logic [11:0] a, input logic [31:0] s, input logic [31:0] c);
        if (a == 12'h300) mst = (mst & ~c) | s;
        if (a == 12'h341) mepc = (mepc & ~c) | s;
        if (a == 12'h342) mcause = (mcause & ~c) | s;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_en"}, 32'(csr_en), 0);
        check({tag, "_gnt"}, 32'(core_gnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'({trap_done, mret_done}), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic accept(input bit is_trap, input bit with_mret, input bit with_core,
                          input logic [31:0] pc, input logic [31:0] cause);
        @(negedge clk_i);
        if (is_trap) begin
            lat_pc = pc;
            lat_cause = cause;
        end
        trap_req = is_trap;
        mret_req = !is_trap || with_mret;
        core_req = with_core;
        trap_pc = pc;
        trap_cause = cause;
        core_addr = 12'h300;
        core_set = $urandom;
        core_clear = $urandom;
        csr_ack = 0;
        #1 quiet("accept");
        @(posedge clk_i);
        #1 trap_pc = $urandom;
        trap_cause = $urandom;
    endtask

    // walk the bus steps, acking step stall_step only after nack idle cycles
    task automatic body(input bit is_trap, input int stall_step, input int nack, output bit to);
        int steps;
        logic [11:0] ea;
        logic [11:0] a;
        logic [31:0] s_v;
        logic [31:0] c_v;
        int na;
        bit acked;
        steps = is_trap ? 3 : 1;
        to = 0;
        for (int s = 0; s < steps && !to; s++) begin
            ea = (!is_trap || s == 0) ? 12'h300 : s == 1 ? 12'h341 : 12'h342;
            na = s == stall_step ? nack : 0;
            acked = 0;
            for (int c = 0; c < TO && !acked && !to; c++) begin
                @(negedge clk_i);
                #1 csr_ack = csr_en && mapped(csr_addr) && c >= na;
                #1;
                check("busy", 32'(busy), 1);
                check("en", 32'(csr_en), 1);
                check("addr", 32'(csr_addr), 32'(ea));
                check("gnt_hold", 32'(core_gnt), 0);
                check("disjoint", csr_set & csr_clear, 0);
                if (is_trap && s == 1) begin
                    check("mepc_set", csr_set, lat_pc);
                    check("mepc_clr", csr_clear, ~lat_pc);
                end
                if (is_trap && s == 2) begin
                    check("mcause_set", csr_set, lat_cause);
                    check("mcause_clr", csr_clear, ~lat_cause);
                end
                if (ea == 12'h300) begin
                    ms_set = csr_set;
                    ms_clr = csr_clear;
                end
                check("trap_done", 32'(trap_done), 32'(csr_ack && is_trap && s == 2));
                check("mret_done", 32'(mret_done), 32'(csr_ack && !is_trap));
                check("err", 32'(err), 32'(!csr_ack && c == TO - 1));
                a = csr_addr;
                s_v = csr_set;
                c_v = csr_clear;
                acked = csr_ack;
                to = !csr_ack && c == TO - 1;
                @(posedge clk_i);
                #1;
                if (acked) apply(a, s_v, c_v);
                csr_ack = 0;
            end
        end
    endtask

    task automatic final_check(input bit is_trap, input logic [31:0] o);
        if (is_trap) begin
            check("t_mie", 32'(mst[3]), 0);
            check("t_mpie", 32'(mst[7]), 32'(o[3]));
            check("t_mepc", mepc, lat_pc);
            check("t_mcause", mcause, lat_cause);
        end else begin
            check("r_mie", 32'(mst[3]), 32'(o[7]));
            check("r_mpie", 32'(mst[7]), 1);
        end
        check("ms_other", mst & ~32'h88, o & ~32'h88);
    endtask

    task automatic run(input bit is_trap, input bit with_mret, input bit with_core,
                       input int stall_step, input int nack,
                       input logic [31:0] pc, input logic [31:0] cause);
        logic [31:0] o;
        bit to;
        o = mst;
        accept(is_trap, with_mret, with_core, pc, cause);
        body(is_trap, stall_step, nack, to);
        if (!to) final_check(is_trap, o);
        if (is_trap && with_mret) begin
            o = mst;
            accept(0, 1, with_core, pc, cause);
            body(0, -1, 0, to);
            final_check(0, o);
        end
        @(negedge clk_i);
        trap_req = 0;
        mret_req = 0;
        core_req = 0;
        #1 check("idle_after", 32'(busy), 0);
    endtask

    task automatic core_access(input logic [11:0] a, input logic [31:0] s, input logic [31:0] c,
                               input int cycles);
        bit ok;
        ok = mapped(a);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            core_req = 1;
            core_addr = a;
            core_set = s;
            core_clear = c;
            #1 csr_ack = csr_en && mapped(csr_addr);
            #1;
            check("core_en", 32'(csr_en), 1);
            check("core_addr", 32'(csr_addr), 32'(a));
            check("core_set", csr_set, s);
            check("core_clr", csr_clear, c);
            check("core_gnt", 32'(core_gnt), 32'(ok));
            check("core_busy", 32'(busy), 0);
            check("core_err", 32'(err), 0);
            @(posedge clk_i);
            #1;
            if (csr_ack) apply(a, s, c);
            csr_ack = 0;
        end
        @(negedge clk_i);
        core_req = 0;
    endtask

    initial begin
        #2 rst_i = 0;
        #1;
        check("rst_addr", 32'(csr_addr), 0);
        check("rst_set", csr_set | csr_clear, 0);
        quiet("rst");
        @(negedge clk_i);
        rst_i = 1;
        #1 quiet("post_rst");

        mst = 32'h08;
        run(1, 0, 0, -1, 0, 32'h100, 32'h8000000B);
        check("t1_set", ms_set, 32'h80);
        check("t1_clr", ms_clr, 32'h08);
        check("t1_mepc", mepc, 32'h100);
        check("t1_mcause", mcause, 32'h8000000B);

        mst = 32'h80;
        run(0, 0, 0, -1, 0, 0, 0);
        check("t2_set", ms_set, 32'h88);
        check("t2_clr", ms_clr, 0);
        check("t2_mst", mst, 32'h88);

        run(1, 1, 1, -1, 0, $urandom, $urandom);

        core_access(12'h300, 32'h08, 0, 1);
        core_access(12'h7C0, $urandom, $urandom, TO + 5);

        mepc = 32'h55;
        run(1, 0, 0, 1, 1000, 32'h200, 32'h7);
        check("t5_mepc_kept", mepc, 32'h55);

        run(1, 0, 0, 2, TO - 1, $urandom, $urandom);

        accept(1, 0, 0, 32'h300, 32'h2);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk_i);
            #1 csr_ack = 1;
            @(posedge clk_i);
            #1 csr_ack = 0;
        end
        @(negedge clk_i);
        #1 check("t6_in_mcause", 32'(csr_addr), 32'h342);
        rst_i = 0;
        #1;
        check("t6_addr", 32'(csr_addr), 0);
        check("t6_set", csr_set | csr_clear, 0);
        quiet("t6");
        trap_req = 0;
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        #1 quiet("t6_release");

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) mst = $urandom;
            if (k == 0)
                run(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2), $urandom_range(0, TO + 2), $urandom, $urandom);
            else if (k == 1)
                run(0, 0, $urandom_range(0, 1) == 1, 0, $urandom_range(0, TO + 2), 0, 0);
            else if (k == 2)
                core_access($urandom_range(0, 1) == 1 ? 12'h341 : 12'h123, $urandom, $urandom, 1);
            else
                run(1, 0, 0, -1, 0, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
